puf_crp_sweeper: RTL

- Host-side initiator for the top-level PUF challenge/response interface (challenge in; restart/ready/response back).
- On `start`, sweeps an inclusive challenge range into the PUF:
  - restarts the PUF for each challenge;
  - waits for a fresh `ready`;
  - captures the response;
  - emits each challenge-response pair (CRP) on a valid/ready output stream.
- Sits between the PUF core and enrollment/CRP-logging logic and replaces manual challenge stepping.

---
 rtl/puf_crp_sweeper.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/puf_crp_sweeper.sv
// puf_crp_sweeper
//   Host-side initiator for a PUF challenge/response core. On start it walks an
//   inclusive challenge range (wrapping modulo 2^CHAL_W). For each challenge it:
//     - restarts the PUF;
//     - waits for ready to drop and then rise again;
//     - captures the response;
//     - hands the challenge/response pair out on a valid/ready stream.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a sweep (only honoured while idle)
//   chall_first/last    inclusive challenge range, sampled on accepted start
//   puf_en              PUF enable, mirrors busy
//   puf_restart         one-cycle restart pulse (the ISSUE cycle)
//   puf_chall           challenge currently presented to the PUF
//   puf_ready           PUF response-valid level
//   puf_response        PUF response
//   out_valid/ready     CRP stream handshake
//   out_chall/out_resp  presented CRP
//   busy                sweep in progress
//   done                one-cycle pulse on normal completion
//   timeout_err         sticky abort flag, cleared by the next start
//   crp_count           CRPs handed off in the current/last sweep
module puf_crp_sweeper #(
  parameter int CHAL_W  = 8,
  parameter int RESP_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] chall_first,
  input  logic [CHAL_W-1:0] chall_last,
  output logic              puf_en,
  output logic              puf_restart,
  output logic [CHAL_W-1:0] puf_chall,
  input  logic              puf_ready,
  input  logic [RESP_W-1:0] puf_response,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAL_W-1:0] out_chall,
  output logic [RESP_W-1:0] out_resp,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CHAL_W:0]   crp_count
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The counter holds the number of DROP/WAIT cycles already completed, so the
  // cycle on which it equals TIMEOUT-1 is the last one allowed.
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DROP, S_WAIT, S_OUT, S_FIN
  } state_t;

  state_t            state_reg;
  logic [CHAL_W-1:0] cur_reg;
  logic [CHAL_W-1:0] last_reg;
  logic [TW-1:0]     tcnt_reg;
  logic              restart_reg;
  logic              valid_reg;
  logic [CHAL_W-1:0] ochall_reg;
  logic [RESP_W-1:0] oresp_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              terr_reg;
  logic [CHAL_W:0]   count_reg;

  assign puf_en      = busy_reg;
  assign puf_restart = restart_reg;
  assign puf_chall   = cur_reg;   // cur only changes right before ISSUE
  assign out_valid   = valid_reg;
  assign out_chall   = ochall_reg;
  assign out_resp    = oresp_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign timeout_err = terr_reg;
  assign crp_count   = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cur_reg     <= '0;
      last_reg    <= '0;
      tcnt_reg    <= '0;
      restart_reg <= 1'b0;
      valid_reg   <= 1'b0;
      ochall_reg  <= '0;
      oresp_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      terr_reg    <= 1'b0;
      count_reg   <= '0;
    end else begin
      restart_reg <= 1'b0;
      done_reg    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            cur_reg     <= chall_first;
            last_reg    <= chall_last;
            count_reg   <= '0;
            terr_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            restart_reg <= 1'b1;
            state_reg   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt_reg  <= '0;
          state_reg <= S_DROP;
        end
        S_DROP: begin
          // A ready still high here belongs to the previous evaluation.
          if (tcnt_reg == TLIM) begin
            terr_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
            if (!puf_ready) state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response arriving on the final allowed cycle still wins.
          if (puf_ready) begin
            oresp_reg  <= puf_response;
            ochall_reg <= cur_reg;
            valid_reg  <= 1'b1;
            state_reg  <= S_OUT;
          end else if (tcnt_reg == TLIM) begin
            terr_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            count_reg <= count_reg + 1'b1;
            // Compare before incrementing so a full-range sweep stops at the top.
            if (cur_reg == last_reg) begin
              done_reg  <= 1'b1;
              state_reg <= S_FIN;
            end else begin
              cur_reg     <= cur_reg + 1'b1;
              restart_reg <= 1'b1;
              state_reg   <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
